// File: rtl/sseg_counter_scan.sv
// BCD up/down counter with a multiplexed, registered seven-segment scan driver.
// Define SSEG_LZ_BLANK_EN to blank leading zeros (digit 0 is never blanked).
module sseg_counter_scan #(
    parameter int NDIG     = 4,
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [NDIG*4-1:0]   load_val,
    output logic [NDIG-1:0]     sseg_a_o,
    output logic [6:0]          sseg_c_o,
    output logic                carry_o
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = $clog2(NDIG);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIG - 1);

    logic [TICK_W-1:0]   r_tickCnt;
    logic [SCAN_W-1:0]   r_scanCnt;
    logic [IDX_W-1:0]    r_digIdx;
    logic [NDIG*4-1:0]   r_value;
    logic [NDIG-1:0]     r_anode;
    logic [6:0]          r_cathode;
    logic                r_carry;

    logic                w_tick;
    logic                w_scanStep;
    logic                w_wrap;
    logic                w_allNine;
    logic                w_allZero;
    logic [NDIG*4-1:0]   w_loadSat;
    logic [NDIG*4-1:0]   w_nextValue;
    logic [NDIG-1:0]     w_blank;
    logic [3:0]          w_curDigit;
    logic                w_curBlank;

    function automatic logic [6:0] segEncode(input logic [3:0] digit);
        case (digit)
            4'd0:    segEncode = 7'b1000000;
            4'd1:    segEncode = 7'b1111001;
            4'd2:    segEncode = 7'b0100100;
            4'd3:    segEncode = 7'b0110000;
            4'd4:    segEncode = 7'b0011001;
            4'd5:    segEncode = 7'b0010010;
            4'd6:    segEncode = 7'b0000010;
            4'd7:    segEncode = 7'b1111000;
            4'd8:    segEncode = 7'b0000000;
            4'd9:    segEncode = 7'b0010000;
            default: segEncode = 7'b1111111;
        endcase
    endfunction

    // Ripple a decimal carry/borrow from digit 0 upward; stops at the first digit that does not wrap.
    function automatic logic [NDIG*4-1:0] bcdStep(input logic [NDIG*4-1:0] value, input logic up);
        logic [NDIG*4-1:0] result;
        logic [3:0]        digit;
        logic              ripple;
        result = value;
        ripple = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            digit = value[i*4 +: 4];
            if (ripple) begin
                if (up) begin
                    if (digit == 4'd9) begin
                        digit = 4'd0;
                    end else begin
                        digit  = digit + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        digit = 4'd9;
                    end else begin
                        digit  = digit - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
            result[i*4 +: 4] = digit;
        end
        return result;
    endfunction

    assign w_tick      = en && (r_tickCnt == TICK_LAST);
    assign w_scanStep  = (r_scanCnt == SCAN_LAST);
    assign w_nextValue = bcdStep(r_value, up_dn);
    assign w_wrap      = up_dn ? w_allNine : w_allZero;

    always_comb begin
        w_allNine = 1'b1;
        w_allZero = 1'b1;
        w_loadSat = '0;
        for (int i = 0; i < NDIG; i++) begin
            w_allNine = w_allNine && (r_value[i*4 +: 4] == 4'd9);
            w_allZero = w_allZero && (r_value[i*4 +: 4] == 4'd0);
            w_loadSat[i*4 +: 4] = (load_val[i*4 +: 4] > 4'd9) ? 4'd9 : load_val[i*4 +: 4];
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        w_blank = '0;
`ifdef SSEG_LZ_BLANK_EN
        begin
            logic zeroAbove;
            zeroAbove = 1'b1;
            for (int i = NDIG - 1; i > 0; i--) begin
                zeroAbove  = zeroAbove && (r_value[i*4 +: 4] == 4'd0);
                w_blank[i] = zeroAbove;
            end
        end
`endif
    end

    always_comb begin
        w_curDigit = 4'd0;
        w_curBlank = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_digIdx == IDX_W'(i)) begin
                w_curDigit = r_value[i*4 +: 4];
                w_curBlank = w_blank[i];
            end
        end
    end

    // Load beats a coincident tick and never produces a wrap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tickCnt <= '0;
            r_value   <= '0;
            r_carry   <= 1'b0;
        end else if (load) begin
            r_tickCnt <= '0;
            r_value   <= w_loadSat;
            r_carry   <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (en) begin
                if (w_tick) begin
                    r_tickCnt <= '0;
                    r_value   <= w_nextValue;
                    r_carry   <= w_wrap;
                end else begin
                    r_tickCnt <= r_tickCnt + 1'b1;
                end
            end
        end
    end

    // Anode and cathode come from the same index in the same edge, so digits switch cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scanCnt <= '0;
            r_digIdx  <= '0;
            r_anode   <= '1;
            r_cathode <= 7'b1111111;
        end else begin
            if (w_scanStep) begin
                r_scanCnt <= '0;
                r_digIdx  <= (r_digIdx == IDX_LAST) ? '0 : r_digIdx + 1'b1;
            end else begin
                r_scanCnt <= r_scanCnt + 1'b1;
            end
            r_anode   <= ~(NDIG'(1) << r_digIdx);
            r_cathode <= w_curBlank ? 7'b1111111 : segEncode(w_curDigit);
        end
    end

    assign sseg_a_o = r_anode;
    assign sseg_c_o = r_cathode;
    assign carry_o  = r_carry;

endmodule

// File: tb/tb_sseg_counter_scan.sv
// Directed scoreboard bench for sseg_counter_scan (NDIG=4, TICK_DIV=2, SCAN_DIV=4).
// Define SSEG_LZ_BLANK_EN for both files to exercise leading-zero blanking.
module tb_sseg_counter_scan;

    localparam int NDIG = 4;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam int SEL_A     = 0;
    localparam int SEL_C     = 1;
    localparam int SEL_CARRY = 2;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } sbItem_t;

    logic              clk;
    logic              reset;
    logic              en;
    logic              up_dn;
    logic              load;
    logic [NDIG*4-1:0] load_val;
    logic [NDIG-1:0]   sseg_a_o;
    logic [6:0]        sseg_c_o;
    logic              carry_o;

    sbItem_t sbQ[$];
    int      nAssert = 0;
    int      nFail   = 0;

    sseg_counter_scan #(
        .NDIG     (NDIG),
        .TICK_DIV (2),
        .SCAN_DIV (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .sseg_a_o (sseg_a_o),
        .sseg_c_o (sseg_c_o),
        .carry_o  (carry_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pushExp(input string tag, input int sel, input logic [31:0] val);
        sbItem_t item;
        item.tag = tag;
        item.sel = sel;
        item.val = val;
        sbQ.push_back(item);
    endtask

    task automatic checkOutput();
        sbItem_t     item;
        logic [31:0] obs;
        nAssert++;
        if (sbQ.size() == 0) begin
            nFail++;
            $display("FAIL sb_empty observed=0 expected=1 queued items");
            return;
        end
        item = sbQ.pop_front();
        case (item.sel)
            SEL_A:   obs = 32'(sseg_a_o);
            SEL_C:   obs = 32'(sseg_c_o);
            default: obs = 32'(carry_o);
        endcase
        assert (obs === item.val) else begin
            nFail++;
            $error("FAIL %s observed=%0b expected=%0b", item.tag, obs, item.val);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] val, input logic enV, input logic upV);
        load     = 1'b1;
        load_val = val;
        en       = enV;
        up_dn    = upV;
        stepCycle();
        load     = 1'b0;
    endtask

    // Align to the start of the digit-0 window, then compare one full 16-cycle scan frame.
    task automatic scanFrame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
        logic [NDIG-1:0] prevA;
        logic [6:0]      expC [4];
        logic [NDIG-1:0] expA [4];
        bit              found;
        expC[0] = e0; expC[1] = e1; expC[2] = e2; expC[3] = e3;
        expA[0] = 4'b1110; expA[1] = 4'b1101; expA[2] = 4'b1011; expA[3] = 4'b0111;
        found = 1'b0;
        stepCycle();
        for (int n = 0; n < 40 && !found; n++) begin
            prevA = sseg_a_o;
            stepCycle();
            if (sseg_a_o == 4'b1110 && prevA != 4'b1110) found = 1'b1;
        end
        nAssert++;
        assert (found) else begin
            nFail++;
            $error("FAIL %s_sync observed=%0b expected=1", tag, found);
        end
        for (int k = 0; k < 16; k++) begin
            pushExp({tag, "_a"}, SEL_A, 32'(expA[k / 4]));
            pushExp({tag, "_c"}, SEL_C, 32'(expC[k / 4]));
            checkOutput();
            checkOutput();
            if (k < 15) stepCycle();
        end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = '0;

        for (int k = 0; k < 5; k++) begin
            pushExp("rst_a", SEL_A, 32'hF);
            pushExp("rst_c", SEL_C, 32'(SEG_OFF));
            pushExp("rst_carry", SEL_CARRY, 32'h0);
            stepCycle();
            checkOutput(); checkOutput(); checkOutput();
        end
        reset = 1'b0;
        pushExp("post_rst_a", SEL_A, 32'b1110);
        pushExp("post_rst_c", SEL_C, 32'(SEG_0));
        stepCycle();
        checkOutput(); checkOutput();

        // Count up through 9999 into a wrap.
        applyStimulus(16'h9998, 1'b1, 1'b1);
        pushExp("up_carry_l1", SEL_CARRY, 32'h0);
        stepCycle(); checkOutput();
        pushExp("up_carry_l2", SEL_CARRY, 32'h0);
        stepCycle(); checkOutput();
        pushExp("up_9999_c", SEL_C, 32'(SEG_9));
        pushExp("up_carry_l3", SEL_CARRY, 32'h0);
        stepCycle(); checkOutput(); checkOutput();
        pushExp("up_wrap_carry", SEL_CARRY, 32'h1);
        stepCycle(); checkOutput();
        en = 1'b0;
        pushExp("up_wrap_c", SEL_C, 32'(SEG_0));
        pushExp("up_carry_once", SEL_CARRY, 32'h0);
        stepCycle(); checkOutput(); checkOutput();

        // Count down from 0000 into a wrap, then freeze with en low.
        applyStimulus(16'h0000, 1'b1, 1'b0);
        pushExp("dn_carry_l1", SEL_CARRY, 32'h0);
        stepCycle(); checkOutput();
        pushExp("dn_wrap_carry", SEL_CARRY, 32'h1);
        stepCycle(); checkOutput();
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            pushExp("hold_c", SEL_C, 32'(SEG_9));
            pushExp("hold_carry", SEL_CARRY, 32'h0);
            stepCycle(); checkOutput(); checkOutput();
        end

        // Saturating load and the full scan pattern.
        applyStimulus(16'h3A5F, 1'b0, 1'b1);
        scanFrame("scan3959", SEG_9, SEG_5, SEG_9, SEG_3);

        // Load coinciding with a tick, then reset mid-count.
        applyStimulus(16'h9999, 1'b1, 1'b1);
        pushExp("prio_carry_l1", SEL_CARRY, 32'h0);
        stepCycle(); checkOutput();
        load     = 1'b1;
        load_val = 16'h5555;
        pushExp("prio_carry", SEL_CARRY, 32'h0);
        stepCycle(); checkOutput();
        load = 1'b0;
        pushExp("prio_c", SEL_C, 32'(SEG_5));
        pushExp("prio_carry_l3", SEL_CARRY, 32'h0);
        stepCycle(); checkOutput(); checkOutput();
        reset = 1'b1;
        pushExp("midrst_a", SEL_A, 32'hF);
        pushExp("midrst_c", SEL_C, 32'(SEG_OFF));
        pushExp("midrst_carry", SEL_CARRY, 32'h0);
        stepCycle(); checkOutput(); checkOutput(); checkOutput();
        reset = 1'b0;
        en    = 1'b0;
        pushExp("midrst_rel_a", SEL_A, 32'b1110);
        pushExp("midrst_rel_c", SEL_C, 32'(SEG_0));
        stepCycle(); checkOutput(); checkOutput();

        // Leading zeros: blanked only when the option is built in.
        applyStimulus(16'h0042, 1'b0, 1'b1);
`ifdef SSEG_LZ_BLANK_EN
        scanFrame("lz0042", SEG_2, SEG_4, SEG_OFF, SEG_OFF);
`else
        scanFrame("lz0042", SEG_2, SEG_4, SEG_0, SEG_0);
`endif
        applyStimulus(16'h0000, 1'b0, 1'b1);
`ifdef SSEG_LZ_BLANK_EN
        scanFrame("lz0000", SEG_0, SEG_OFF, SEG_OFF, SEG_OFF);
`else
        scanFrame("lz0000", SEG_0, SEG_0, SEG_0, SEG_0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
